// File: rtl/ds_pkg.sv
// Shared constants and helpers for the delta-sigma loop-filter stages.
// Default widths plus the ±full-scale feedback generator.
package ds_pkg;

  localparam int WIDTH    = 41;
  localparam int FB_SHIFT = 36;
  localparam int LIM_EXP  = 39;
  localparam int CNT_W    = 16;

  // Signed ±2^shift feedback for a one-bit quantizer decision.
  function automatic logic signed [63:0] fb_value(
    input logic        fb,
    input int unsigned shift
  );
    logic signed [63:0] fs;
    fs = 64'sd1 <<< shift;
    return fb ? fs : -fs;
  endfunction

endpackage

// File: rtl/ds_sat_clamp.sv
// Symmetric clamp of a (WIDTH+2)-bit sum to [-L, +L], L = 2^LIM_EXP - 1.
// Purely combinational; the flag reports that clamping took place.
module ds_sat_clamp #(
  parameter int WIDTH   = 41,
  parameter int LIM_EXP = 39
) (
  input  logic signed [WIDTH+1:0] i_sum,
  output logic signed [WIDTH-1:0] o_val,
  output logic                    o_sat
);

  localparam logic signed [WIDTH+1:0] LIM_P =
    {{(WIDTH+2-LIM_EXP){1'b0}}, {LIM_EXP{1'b1}}};
  localparam logic signed [WIDTH+1:0] LIM_N = -LIM_P;

  logic w_hi;
  logic w_lo;

  assign w_hi = (i_sum > LIM_P);
  assign w_lo = (i_sum < LIM_N);

  // Select the limit on overflow, else pass the low WIDTH bits through.
  always_comb begin
    o_val = i_sum[WIDTH-1:0];
    if (w_hi) o_val = LIM_P[WIDTH-1:0];
    if (w_lo) o_val = LIM_N[WIDTH-1:0];
  end

  assign o_sat = w_hi | w_lo;

endmodule

// File: rtl/ds_integrator.sv
// Delaying integrator of the delta-sigma loop filter: y += x - v, clamped.
// Sum is carried at WIDTH+2 bits so it never wraps before the clamp.
module ds_integrator
  import ds_pkg::*;
#(
  parameter int WIDTH    = ds_pkg::WIDTH,
  parameter int FB_SHIFT = ds_pkg::FB_SHIFT,
  parameter int LIM_EXP  = ds_pkg::LIM_EXP,
  parameter int CNT_W    = ds_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [WIDTH-1:0] in,
  input  logic                    fb,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid,
  output logic                    sat,
  output logic [CNT_W-1:0]        sat_cnt
);

  if (!(FB_SHIFT < LIM_EXP)) begin : g_bad_fb
    $error("ds_integrator: FB_SHIFT must be below LIM_EXP");
  end
  if (!(LIM_EXP <= WIDTH - 2)) begin : g_bad_lim
    $error("ds_integrator: LIM_EXP must not exceed WIDTH-2");
  end

  logic signed [WIDTH-1:0] r_y;
  logic                    r_vld;
  logic                    r_sat;
  logic [CNT_W-1:0]        r_cnt;

  logic signed [WIDTH+1:0] w_fb;
  logic signed [WIDTH+1:0] w_sum;
  logic signed [WIDTH-1:0] w_clamped;
  logic                    w_sat;

  assign w_fb  = (WIDTH+2)'(fb_value(fb, FB_SHIFT));
  assign w_sum = {{2{r_y[WIDTH-1]}}, r_y}
               + {{2{in[WIDTH-1]}}, in}
               - w_fb;

  ds_sat_clamp #(
    .WIDTH   (WIDTH),
    .LIM_EXP (LIM_EXP)
  ) u_clamp (
    .i_sum (w_sum),
    .o_val (w_clamped),
    .o_sat (w_sat)
  );

  // State update: reset beats clear, clear beats the sample strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y   <= '0;
      r_vld <= 1'b0;
      r_sat <= 1'b0;
      r_cnt <= '0;
    end else if (clr) begin
      r_y   <= '0;
      r_vld <= 1'b0;
      r_sat <= 1'b0;
      r_cnt <= '0;
    end else if (en) begin
      r_y   <= w_clamped;
      r_vld <= 1'b1;
      r_sat <= w_sat;
      if (w_sat && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end else begin
      r_vld <= 1'b0;
    end
  end

  assign out       = r_y;
  assign out_valid = r_vld;
  assign sat       = r_sat;
  assign sat_cnt   = r_cnt;

endmodule

// File: tb/tb_ds_integrator.sv
// Directed self-checking bench for ds_integrator.
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_ds_integrator;

  localparam logic signed [40:0] FS  = 41'sd68719476736;
  localparam logic signed [40:0] P38 = 41'sd274877906944;
  localparam logic signed [40:0] LIM = 41'sd549755813887;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               clr;
  logic signed [40:0] in_s;
  logic               fb;
  logic signed [40:0] out_s;
  logic               out_valid;
  logic               sat;
  logic [15:0]        sat_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ds_integrator dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .in        (in_s),
    .fb        (fb),
    .out       (out_s),
    .out_valid (out_valid),
    .sat       (sat),
    .sat_cnt   (sat_cnt)
  );

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic signed [63:0] e_out,
                         input logic e_vld,
                         input logic e_sat,
                         input logic [15:0] e_cnt);
    chk({tag, ".out"}, out_s, e_out);
    chk({tag, ".valid"}, {63'd0, out_valid}, {63'd0, e_vld});
    chk({tag, ".sat"}, {63'd0, sat}, {63'd0, e_sat});
    chk({tag, ".cnt"}, {48'd0, sat_cnt}, {48'd0, e_cnt});
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0;
    in_s = 41'sd12345; fb = 1'b1;

    tick(); chk_all("rst1", 0, 0, 0, 0);
    tick(); chk_all("rst2", 0, 0, 0, 0);

    rst = 1'b0; in_s = 41'sd5; fb = 1'b1;
    tick(); chk_all("fbc1", 41'sd5 - FS, 1, 0, 0);
    fb = 1'b0;
    tick(); chk_all("fbc2", 10, 1, 0, 0);

    clr = 1'b1;
    tick(); chk_all("clrA", 0, 0, 0, 0);
    clr = 1'b0;

    in_s = P38; fb = 1'b0;
    tick(); chk_all("pos1", 41'sd343597383680, 1, 0, 0);
    tick(); chk_all("pos2", LIM, 1, 1, 1);
    tick(); chk_all("pos3", LIM, 1, 1, 2);

    clr = 1'b1;
    tick(); chk_all("clrB", 0, 0, 0, 0);
    clr = 1'b0;

    in_s = -P38; fb = 1'b1;
    tick(); chk_all("neg1", -41'sd343597383680, 1, 0, 0);
    tick(); chk_all("neg2", -LIM, 1, 1, 1);
    tick(); chk_all("neg3", -LIM, 1, 1, 2);
    in_s = 41'sd0; fb = 1'b0;
    tick(); chk_all("rec", -LIM + FS, 1, 0, 2);

    en = 1'b0; in_s = 41'sd777; fb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gap.out", out_s, -41'sd481036337151);
      chk("gap.valid", {63'd0, out_valid}, 64'sd0);
    end
    chk("gap.cnt", {48'd0, sat_cnt}, 64'sd2);

    en = 1'b1; clr = 1'b1; in_s = 41'sd999;
    tick(); chk_all("clrC", 0, 0, 0, 0);
    clr = 1'b0;

    in_s = P38; fb = 1'b0;
    for (int i = 0; i < 65536; i++) tick();
    chk_all("cnt65535", LIM, 1, 1, 16'hFFFF);
    tick(); chk_all("cntHold", LIM, 1, 1, 16'hFFFF);

    en = 1'b0;
    tick(); chk_all("idleSat", LIM, 0, 1, 16'hFFFF);

    rst = 1'b1;
    tick(); chk_all("midRst", 0, 0, 0, 0);
    rst = 1'b0; en = 1'b1; in_s = 41'sd5; fb = 1'b1;
    tick(); chk_all("postRst", 41'sd5 - FS, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
